bus_coherence_ctrl: RTL and testbench

Snooping bus controller between the two per-core data-cache control FSMs and the shared RAM port. It arbitrates the caches' block requests round-robin and issues snoops and invalidates to the non-requesting cache. It sources each block either from a dirty peer (cache-to-cache, with a concurrent RAM writeback) or from RAM, and passes eviction writebacks straight through. It consumes the cache FSM outputs `dREN`, `dWEN`, `daddr`, `store`, `cctrans`, `ccwrite` and produces its inputs `dwait`, `ccwait`, `ccsnoopaddr`.

---
 rtl/bus_coherence_ctrl.sv | 161 ++++++++++++++++
 tb/tb_bus_coherence_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_coherence_ctrl.sv
// Snooping bus controller for two data caches sharing one RAM port.
// Round-robin grant, snoop/invalidate of the peer, cache-to-cache fills with RAM writeback.
module bus_coherence_ctrl #(
  parameter int unsigned CPUS      = 2,
  parameter int unsigned BLK_WORDS = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [CPUS-1:0]        dREN,
  input  logic [CPUS-1:0]        dWEN,
  input  logic [CPUS-1:0][31:0]  daddr,
  input  logic [CPUS-1:0][31:0]  dstore,
  input  logic [CPUS-1:0]        cctrans,
  input  logic [CPUS-1:0]        ccwrite,
  output logic [CPUS-1:0]        dwait,
  output logic [CPUS-1:0][31:0]  dload,
  output logic [CPUS-1:0]        ccwait,
  output logic [CPUS-1:0]        ccinv,
  output logic [CPUS-1:0][31:0]  ccsnoopaddr,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [31:0]            ramaddr,
  output logic [31:0]            ramstore,
  input  logic [31:0]            ramload,
  input  logic                   ramready
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EVICT = 3'd1,
    SNOOP = 3'd2,
    C2C   = 3'd3,
    MEMRD = 3'd4
  } state_t;

  state_t          state;
  state_t          next_state;
  logic            req_id;
  logic            peer_id;
  logic            gnt_last;
  logic            gnt;
  logic            wcnt;
  logic            last_word;
  logic            peer_dirty;
  logic [CPUS-1:0] request;

  assign peer_id    = ~req_id;
  assign request    = dREN | dWEN | cctrans;
  assign peer_dirty = cctrans[peer_id] & ccwrite[peer_id];
  assign last_word  = (wcnt == 1'(BLK_WORDS - 1));

  // Round-robin arbiter: on a tie the cache that was not granted last wins.
  always_comb begin
    gnt = 1'b0;
    if (&request)
      gnt = ~gnt_last;
    else if (request[1] && !request[0])
      gnt = 1'b1;
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RST)
      state <= IDLE;
    else
      state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (|request)
          next_state = dWEN[gnt] ? EVICT : SNOOP;
      end
      SNOOP: begin
        if (peer_dirty)
          next_state = C2C;
        else if (dREN[req_id])
          next_state = MEMRD;
        else
          next_state = IDLE;
      end
      EVICT, C2C, MEMRD: begin
        if (ramready && last_word)
          next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Grant bookkeeping and per-block word counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      req_id   <= 1'b0;
      gnt_last <= 1'b1;
      wcnt     <= 1'b0;
    end else begin
      if (state == IDLE && |request) begin
        req_id   <= gnt;
        gnt_last <= gnt;
      end
      if ((state == IDLE || state == SNOOP) &&
          (next_state == EVICT || next_state == C2C || next_state == MEMRD))
        wcnt <= 1'b0;
      else if ((state == EVICT || state == C2C || state == MEMRD) && ramready)
        wcnt <= wcnt + 1'b1;
    end
  end

  // Output logic; word handshakes follow ramready within the same cycle.
  always_comb begin
    dwait       = '1;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    case (state)
      EVICT: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr[req_id];
        ramstore = dstore[req_id];
        if (ramready)
          dwait[req_id] = 1'b0;
      end
      SNOOP: begin
        ccwait[peer_id]      = 1'b1;
        ccsnoopaddr[peer_id] = daddr[req_id];
        ccinv[peer_id]       = ccwrite[req_id];
        // Upgrade with a clean peer completes in the snoop cycle itself.
        if (!peer_dirty && !dREN[req_id])
          dwait[req_id] = 1'b0;
      end
      C2C: begin
        ccwait[peer_id] = 1'b1;
        ramWEN          = 1'b1;
        ramaddr         = daddr[req_id];
        ramstore        = dstore[peer_id];
        dload[req_id]   = dstore[peer_id];
        if (ramready) begin
          dwait[req_id]  = 1'b0;
          dwait[peer_id] = 1'b0;
        end
      end
      MEMRD: begin
        ramREN        = 1'b1;
        ramaddr       = daddr[req_id];
        dload[req_id] = ramload;
        if (ramready)
          dwait[req_id] = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_coherence_ctrl.sv
// Self-checking bench for bus_coherence_ctrl: behavioural caches and a latency-configurable RAM.
module tb_bus_coherence_ctrl;

  logic              CLK = 1'b0;
  logic              RST;
  logic [1:0]        dREN, dWEN, cctrans, ccwrite;
  logic [1:0][31:0]  daddr, dstore;
  logic [1:0]        dwait, ccwait, ccinv;
  logic [1:0][31:0]  dload, ccsnoopaddr;
  logic              ramREN, ramWEN;
  logic [31:0]       ramaddr, ramstore, ramload;
  logic              ramready;

  int n_checks = 0;
  int n_fail   = 0;
  int lat_m1   = 0;
  int rcnt     = 0;

  typedef struct {
    int          cpu;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   gq[$];

  bus_coherence_ctrl #(.CPUS(2), .BLK_WORDS(2)) dut (
    .CLK(CLK), .RST(RST),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .cctrans(cctrans), .ccwrite(ccwrite),
    .dwait(dwait), .dload(dload), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  // RAM model: ready after lat_m1+1 cycles of a held strobe.
  assign ramload  = ramREN ? mem_word(ramaddr) : 32'hDEAD_BEEF;
  assign ramready = (ramREN || ramWEN) && (rcnt == lat_m1);
  always @(posedge CLK) begin
    if (!(ramREN || ramWEN) || ramready) rcnt <= 0;
    else rcnt <= rcnt + 1;
  end

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0; daddr = '0; dstore = '0;
    repeat (2) next_cycle();
    sample();
    n_checks++; if (dwait !== 2'b11) begin n_fail++; $display("FAIL reset_dwait got %b want 11", dwait); end
    n_checks++; if (ccwait !== 2'b00 || ccinv !== 2'b00) begin n_fail++; $display("FAIL reset_cc got ccwait=%b ccinv=%b want 00", ccwait, ccinv); end
    n_checks++; if ({ramREN, ramWEN} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes got %b want 00", {ramREN, ramWEN}); end
    n_checks++; if (ramaddr !== 32'h0 || dload !== '0) begin n_fail++; $display("FAIL reset_data got ramaddr=%h dload=%h want 0", ramaddr, dload); end
    next_cycle();
    RST = 1'b0;
  endtask

  task automatic test_tie_break();
    int   word[2];
    bit   adv[2];
    bit   saw_snoop0;
    exp_t e;
    word = '{0, 0};
    saw_snoop0 = 1'b0;
    daddr[0] = 32'h40; daddr[1] = 32'h300;
    for (int c = 0; c < 2; c++)
      for (int w = 0; w < 2; w++) begin
        e.cpu  = c;
        e.addr = (c == 0 ? 32'h40 : 32'h300) + 32'(4 * w);
        e.data = mem_word(e.addr);
        sb.push_back(e);
      end
    dREN = 2'b11;
    for (int cyc = 0; cyc < 30 && sb.size() > 0; cyc++) begin
      sample();
      adv = '{1'b0, 1'b0};
      n_checks++; if (ramREN && ramWEN) begin n_fail++; $display("FAIL tie_strobes both RAM strobes high at cycle %0d", cyc); end
      if (ccwait[0]) begin
        saw_snoop0 = 1'b1;
        n_checks++; if (ccsnoopaddr[0] !== 32'h300) begin n_fail++; $display("FAIL tie_snoopaddr got %h want 00000300", ccsnoopaddr[0]); end
      end
      for (int i = 0; i < 2; i++)
        if (dwait[i] === 1'b0 && sb.size() > 0) begin
          e = sb.pop_front();
          n_checks++;
          if (e.cpu != i || dload[i] !== e.data || ramaddr !== e.addr) begin
            n_fail++;
            $display("FAIL tie_word got cpu=%0d addr=%h data=%h want cpu=%0d addr=%h data=%h", i, ramaddr, dload[i], e.cpu, e.addr, e.data);
          end
          if (i == 0 && word[0] == 1) begin
            n_checks++; if (cyc != 3) begin n_fail++; $display("FAIL tie_latency fill done at cycle %0d want 3", cyc); end
          end
          adv[i] = 1'b1;
        end
      next_cycle();
      for (int i = 0; i < 2; i++)
        if (adv[i]) begin
          word[i]++;
          daddr[i] = daddr[i] + 32'd4;
          if (word[i] == 2) dREN[i] = 1'b0;
        end
    end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL tie_timeout %0d words outstanding want 0", sb.size()); sb.delete(); end
    n_checks++; if (saw_snoop0 !== 1'b1) begin n_fail++; $display("FAIL tie_snoop0 got %b want 1", saw_snoop0); end
    dREN = '0;
  endtask

  task automatic test_c2c();
    int   word;
    bit   adv;
    exp_t e;
    word = 0;
    e.cpu = 0; e.addr = 32'h100; e.data = 32'hAAAA; sb.push_back(e);
    e.cpu = 0; e.addr = 32'h104; e.data = 32'hBBBB; sb.push_back(e);
    daddr[0] = 32'h100; dREN[0] = 1'b1; cctrans[0] = 1'b1; ccwrite[0] = 1'b0;
    sample();
    n_checks++; if (dwait !== 2'b11) begin n_fail++; $display("FAIL c2c_idle_dwait got %b want 11", dwait); end
    next_cycle();
    cctrans[1] = 1'b1; ccwrite[1] = 1'b1; dstore[1] = 32'hAAAA;
    sample();
    n_checks++;
    if (ccwait[1] !== 1'b1 || ccinv[1] !== 1'b0 || ccsnoopaddr[1] !== 32'h100 || ramREN || ramWEN) begin
      n_fail++;
      $display("FAIL c2c_snoop got ccwait=%b ccinv=%b addr=%h ren=%b wen=%b want 1 0 00000100 0 0", ccwait[1], ccinv[1], ccsnoopaddr[1], ramREN, ramWEN);
    end
    next_cycle();
    for (int cyc = 0; cyc < 10 && sb.size() > 0; cyc++) begin
      sample();
      adv = 1'b0;
      if (dwait[0] === 1'b0) begin
        e = sb.pop_front();
        n_checks++;
        if (dload[0] !== e.data || ramaddr !== e.addr || ramstore !== e.data || !ramWEN || ramREN) begin
          n_fail++;
          $display("FAIL c2c_word got dload=%h addr=%h store=%h wen=%b ren=%b want %h %h %h 1 0", dload[0], ramaddr, ramstore, ramWEN, ramREN, e.data, e.addr, e.data);
        end
        n_checks++;
        if (dwait[1] !== 1'b0 || ccwait[1] !== 1'b1 || ccinv[1] !== 1'b0) begin
          n_fail++;
          $display("FAIL c2c_peer got dwait1=%b ccwait1=%b ccinv1=%b want 0 1 0", dwait[1], ccwait[1], ccinv[1]);
        end
        adv = 1'b1;
      end
      next_cycle();
      if (adv) begin
        word++;
        daddr[0] = daddr[0] + 32'd4;
        dstore[1] = 32'hBBBB;
        if (word == 2) begin dREN = '0; cctrans = '0; ccwrite = '0; end
      end
    end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL c2c_timeout %0d words outstanding want 0", sb.size()); sb.delete(); end
    dREN = '0; cctrans = '0; ccwrite = '0;
    sample();
    n_checks++; if (ccwait !== 2'b00 || dwait !== 2'b11) begin n_fail++; $display("FAIL c2c_end got ccwait=%b dwait=%b want 00 11", ccwait, dwait); end
    next_cycle();
  endtask

  task automatic test_upgrade();
    daddr[0] = 32'h180; cctrans[0] = 1'b1; ccwrite[0] = 1'b1; dREN = '0;
    sample();
    n_checks++; if (dwait !== 2'b11 || ccinv !== 2'b00) begin n_fail++; $display("FAIL upg_idle got dwait=%b ccinv=%b want 11 00", dwait, ccinv); end
    next_cycle();
    sample();
    n_checks++; if (ccinv !== 2'b10 || ccwait !== 2'b10) begin n_fail++; $display("FAIL upg_inv got ccinv=%b ccwait=%b want 10 10", ccinv, ccwait); end
    n_checks++; if (dwait !== 2'b10) begin n_fail++; $display("FAIL upg_ack got dwait=%b want 10", dwait); end
    n_checks++; if (ramREN || ramWEN) begin n_fail++; $display("FAIL upg_ram got ren=%b wen=%b want 0 0", ramREN, ramWEN); end
    next_cycle();
    cctrans = '0; ccwrite = '0;
    sample();
    n_checks++; if (ccinv !== 2'b00 || dwait !== 2'b11 || ramREN || ramWEN) begin n_fail++; $display("FAIL upg_end got ccinv=%b dwait=%b ren=%b wen=%b want 00 11 0 0", ccinv, dwait, ramREN, ramWEN); end
    next_cycle();
  endtask

  task automatic test_evict_slow();
    int   word, held, lows;
    bit   adv;
    exp_t e;
    word = 0; held = 0; lows = 0;
    lat_m1 = 2;
    e.cpu = 1; e.addr = 32'h200; e.data = 32'h1111_2000; sb.push_back(e);
    e.cpu = 1; e.addr = 32'h204; e.data = 32'h1111_2004; sb.push_back(e);
    daddr[1] = 32'h200; dstore[1] = 32'h1111_2000; dWEN[1] = 1'b1;
    for (int cyc = 0; cyc < 30 && sb.size() > 0; cyc++) begin
      sample();
      adv = 1'b0;
      if (ramWEN) held++;
      n_checks++; if (dwait[0] !== 1'b1 || ramREN) begin n_fail++; $display("FAIL evict_other got dwait0=%b ren=%b want 1 0", dwait[0], ramREN); end
      if (dwait[1] === 1'b0) begin
        e = sb.pop_front();
        lows++;
        n_checks++;
        if (ramaddr !== e.addr || ramstore !== e.data || !ramWEN) begin
          n_fail++;
          $display("FAIL evict_word got addr=%h store=%h wen=%b want %h %h 1", ramaddr, ramstore, ramWEN, e.addr, e.data);
        end
        n_checks++; if (held != 3) begin n_fail++; $display("FAIL evict_hold got %0d cycles want 3", held); end
        held = 0;
        adv = 1'b1;
      end
      next_cycle();
      if (adv) begin
        word++;
        daddr[1] = daddr[1] + 32'd4;
        dstore[1] = dstore[1] + 32'd4;
        if (word == 2) dWEN[1] = 1'b0;
      end
    end
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL evict_timeout %0d words outstanding want 0", sb.size()); sb.delete(); end
    dWEN = '0;
    sample();
    n_checks++; if (ramWEN || dwait !== 2'b11) begin n_fail++; $display("FAIL evict_end got wen=%b dwait=%b want 0 11", ramWEN, dwait); end
    n_checks++; if (lows != 2) begin n_fail++; $display("FAIL evict_lows got %0d want 2", lows); end
    next_cycle();
    lat_m1 = 0;
  endtask

  task automatic test_reset_mid();
    bit found;
    found = 1'b0;
    lat_m1 = 1;
    daddr[0] = 32'h400; dREN[0] = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      sample();
      if (dwait[0] === 1'b0) begin found = 1'b1; break; end
      next_cycle();
    end
    n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL rstmid_first_word timeout got %b want 1", found); end
    n_checks++; if (dload[0] !== mem_word(32'h400) || !ramREN) begin n_fail++; $display("FAIL rstmid_data got %h ren=%b want %h 1", dload[0], ramREN, mem_word(32'h400)); end
    next_cycle();
    daddr[0] = 32'h404; RST = 1'b1;
    sample();
    n_checks++; if (dwait !== 2'b11 || !ramREN) begin n_fail++; $display("FAIL rstmid_pending got dwait=%b ren=%b want 11 1", dwait, ramREN); end
    next_cycle();
    sample();
    n_checks++; if (ramREN || ramWEN || ccwait !== 2'b00) begin n_fail++; $display("FAIL rstmid_strobes got ren=%b wen=%b ccwait=%b want 0 0 00", ramREN, ramWEN, ccwait); end
    n_checks++; if (dwait !== 2'b11 || dload !== '0) begin n_fail++; $display("FAIL rstmid_idle got dwait=%b dload=%h want 11 0", dwait, dload); end
    next_cycle();
    RST = 1'b0; dREN = '0;
    sample();
    n_checks++; if (ramREN || dwait !== 2'b11) begin n_fail++; $display("FAIL rstmid_after got ren=%b dwait=%b want 0 11", ramREN, dwait); end
    next_cycle();
    lat_m1 = 0;
  endtask

  task automatic test_back_to_back();
    int word[2];
    bit adv[2];
    int blocks_done;
    int g;
    word = '{0, 0};
    blocks_done = 0;
    RST = 1'b1;
    next_cycle();
    RST = 1'b0;
    gq.push_back(0); gq.push_back(1); gq.push_back(0); gq.push_back(1);
    daddr[0] = 32'h800; daddr[1] = 32'hC00;
    dREN = 2'b11;
    for (int cyc = 0; cyc < 60 && blocks_done < 4; cyc++) begin
      sample();
      adv = '{1'b0, 1'b0};
      if (ccwait[0] || ccwait[1]) begin
        g = ccwait[1] ? 0 : 1;
        n_checks++;
        if (gq.size() == 0) begin
          n_fail++; $display("FAIL b2b_grant extra grant to cache %0d want none", g);
        end else if (gq[0] != g) begin
          n_fail++; $display("FAIL b2b_grant got cache %0d want cache %0d", g, gq[0]);
          void'(gq.pop_front());
        end else
          void'(gq.pop_front());
      end
      for (int i = 0; i < 2; i++)
        if (dwait[i] === 1'b0) begin
          n_checks++;
          if (dload[i] !== mem_word(daddr[i])) begin n_fail++; $display("FAIL b2b_data cache %0d got %h want %h", i, dload[i], mem_word(daddr[i])); end
          adv[i] = 1'b1;
        end
      next_cycle();
      for (int i = 0; i < 2; i++)
        if (adv[i]) begin
          daddr[i] = daddr[i] + 32'd4;
          word[i]++;
          if (word[i] == 2) begin word[i] = 0; blocks_done++; end
        end
    end
    dREN = '0;
    n_checks++; if (blocks_done != 4) begin n_fail++; $display("FAIL b2b_timeout got %0d blocks want 4", blocks_done); end
    n_checks++; if (gq.size() != 0) begin n_fail++; $display("FAIL b2b_grants %0d grants missing want 0", gq.size()); gq.delete(); end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_tie_break();
    test_c2c();
    test_upgrade();
    test_evict_slow();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish by %0t", $time);
    $fatal(1);
  end

endmodule
